// File: rtl/carga_critica_if.sv
// -----------------------------------------------------------------------------
// carga_critica_if
//   Bundles the battery-gauge inputs and the monitor results of carga_critica.
//
//   Signals
//     carga_bateria1        gauge -> monitor   battery 1 charge, unsigned
//     carga_bateria2        gauge -> monitor   battery 2 charge, unsigned
//     carga_total           monitor -> logic   registered sum of both charges
//     advertencia_critica   monitor -> logic   registered low-charge warning
//     bateria1_descargada   monitor -> logic   registered battery 1 empty
//     bateria2_descargada   monitor -> logic   registered battery 2 empty
//     carga_maxima          monitor -> logic   registered both batteries full
//
//   Modports
//     master : the side that supplies charge levels and reads the results
//     slave  : the monitor itself
// -----------------------------------------------------------------------------
interface carga_critica_if #(
    parameter int ANCHO_CARGA = 4
);

    logic [ANCHO_CARGA-1:0] carga_bateria1;
    logic [ANCHO_CARGA-1:0] carga_bateria2;
    logic [ANCHO_CARGA:0]   carga_total;
    logic                   advertencia_critica;
    logic                   bateria1_descargada;
    logic                   bateria2_descargada;
    logic                   carga_maxima;

    modport master (
        output carga_bateria1,
        output carga_bateria2,
        input  carga_total,
        input  advertencia_critica,
        input  bateria1_descargada,
        input  bateria2_descargada,
        input  carga_maxima
    );

    modport slave (
        input  carga_bateria1,
        input  carga_bateria2,
        output carga_total,
        output advertencia_critica,
        output bateria1_descargada,
        output bateria2_descargada,
        output carga_maxima
    );

endinterface

// File: rtl/carga_critica.sv
// -----------------------------------------------------------------------------
// carga_critica
//   Dual-battery charge monitor. Adds the charge levels of two batteries into
//   a one-bit-wider total and raises a critical warning when that total is at
//   or below UMBRAL. Also reports each battery being fully discharged and the
//   condition where both batteries are full. Every output is a flop, so the
//   input-to-output latency is exactly one clock.
//
//   Parameters
//     ANCHO_CARGA   width of each battery charge input (unsigned)
//     UMBRAL        warning asserted when carga_total <= UMBRAL
//
//   Ports
//     clk    input   rising-edge system clock
//     rst    input   synchronous active-high reset; clears every output
//     bus    slave   carga_critica_if: charge inputs and registered results
// -----------------------------------------------------------------------------
module carga_critica #(
    parameter int ANCHO_CARGA = 4,
    parameter int UMBRAL      = 3
) (
    input  logic            clk,
    input  logic            rst,
    carga_critica_if.slave  bus
);

    localparam int ANCHO_TOTAL = ANCHO_CARGA + 1;

    // Threshold brought to the width of the total so the compare is a plain
    // unsigned compare of equal-width operands.
    localparam logic [ANCHO_TOTAL-1:0] UMBRAL_TOTAL = ANCHO_TOTAL'(UMBRAL);

    // Zero-extend both charges before adding; the extra bit holds the carry,
    // so the sum can never wrap.
    function automatic logic [ANCHO_TOTAL-1:0] sumar_cargas(
        input logic [ANCHO_CARGA-1:0] a,
        input logic [ANCHO_CARGA-1:0] b
    );
        return {1'b0, a} + {1'b0, b};
    endfunction

    function automatic logic es_critica(input logic [ANCHO_TOTAL-1:0] total);
        return (total <= UMBRAL_TOTAL);
    endfunction

    function automatic logic esta_vacia(input logic [ANCHO_CARGA-1:0] carga);
        return (carga == '0);
    endfunction

    function automatic logic esta_llena(input logic [ANCHO_CARGA-1:0] carga);
        return (carga == {ANCHO_CARGA{1'b1}});
    endfunction

    // Stage p0: combinational evaluation of the sampled inputs
    logic [ANCHO_TOTAL-1:0] total_p0;
    logic                   critica_p0;
    logic                   vacia1_p0;
    logic                   vacia2_p0;
    logic                   maxima_p0;

    always_comb begin
        total_p0   = sumar_cargas(bus.carga_bateria1, bus.carga_bateria2);
        critica_p0 = es_critica(total_p0);
        vacia1_p0  = esta_vacia(bus.carga_bateria1);
        vacia2_p0  = esta_vacia(bus.carga_bateria2);
        maxima_p0  = esta_llena(bus.carga_bateria1) & esta_llena(bus.carga_bateria2);
    end

    // Stage p1: output registers. Reset clears everything, including the
    // warning, even though a zero total would otherwise warn.
    logic [ANCHO_TOTAL-1:0] total_p1;
    logic                   critica_p1;
    logic                   vacia1_p1;
    logic                   vacia2_p1;
    logic                   maxima_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            total_p1   <= '0;
            critica_p1 <= 1'b0;
            vacia1_p1  <= 1'b0;
            vacia2_p1  <= 1'b0;
            maxima_p1  <= 1'b0;
        end else begin
            total_p1   <= total_p0;
            critica_p1 <= critica_p0;
            vacia1_p1  <= vacia1_p0;
            vacia2_p1  <= vacia2_p0;
            maxima_p1  <= maxima_p0;
        end
    end

    assign bus.carga_total         = total_p1;
    assign bus.advertencia_critica = critica_p1;
    assign bus.bateria1_descargada = vacia1_p1;
    assign bus.bateria2_descargada = vacia2_p1;
    assign bus.carga_maxima        = maxima_p1;

endmodule

// File: tb/tb_carga_critica.sv
// -----------------------------------------------------------------------------
// tb_carga_critica
//   Self-checking bench for carga_critica. Inputs change on the falling edge;
//   outputs are sampled 1 time unit after the rising edge, and also just
//   before it to confirm nothing moves until the edge.
// -----------------------------------------------------------------------------
module tb_carga_critica;

    localparam int ANCHO = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    carga_critica_if #(.ANCHO_CARGA(ANCHO)) bus ();

    carga_critica #(.ANCHO_CARGA(ANCHO), .UMBRAL(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned vectores = 0;
    int unsigned fallos   = 0;

    // Packed view of all outputs: {total[4:0], advertencia, desc1, desc2, maxima}
    logic [8:0] observado;
    logic [8:0] esperado;
    logic [8:0] previo;

    assign observado = {bus.carga_total, bus.advertencia_critica,
                        bus.bateria1_descargada, bus.bateria2_descargada,
                        bus.carga_maxima};

    // Reference behaviour from the plain arithmetic description of the block.
    function automatic logic [8:0] modelo(input int a, input int b, input bit r);
        int total;
        logic [8:0] res;
        if (r) return 9'd0;
        total    = a + b;
        res[8:4] = 5'(total);
        res[3]   = (total <= 3);
        res[2]   = (a == 0);
        res[1]   = (b == 0);
        res[0]   = (a == 15) && (b == 15);
        return res;
    endfunction

    task automatic poner(input int a, input int b, input bit r);
        @(negedge clk);
        bus.carga_bateria1 = 4'(a);
        bus.carga_bateria2 = 4'(b);
        rst = r;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 2; i++) begin
            poner(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'b1);
            @(posedge clk); #1;
            esperado = 9'd0;
            vectores++;
            if (observado !== esperado) begin
                fallos++;
                $display("FAIL reset_%0d: got %b expected %b", i, observado, esperado);
            end
        end
        // Reset with a zero total must still hold the warning low.
        poner(0, 0, 1'b1);
        @(posedge clk); #1;
        vectores++;
        if (observado !== 9'd0) begin
            fallos++;
            $display("FAIL reset_total_cero: got %b expected %b", observado, 9'd0);
        end
        previo = 9'd0;
    endtask

    task automatic test_dirigido;
        int tabla_a [7] = '{4, 1, 1, 0, 15, 0, 9};
        int tabla_b [7] = '{3, 2, 1, 7, 15, 0, 0};
        for (int i = 0; i < 7; i++) begin
            poner(tabla_a[i], tabla_b[i], 1'b0);
            #1;
            vectores++;
            if (observado !== previo) begin
                fallos++;
                $display("FAIL antes_flanco_%0d: got %b expected %b", i, observado, previo);
            end
            @(posedge clk); #1;
            esperado = modelo(tabla_a[i], tabla_b[i], 1'b0);
            vectores++;
            if (observado !== esperado) begin
                fallos++;
                $display("FAIL dirigido_%0d a=%0d b=%0d: got %b expected %b",
                         i, tabla_a[i], tabla_b[i], observado, esperado);
            end
            previo = esperado;
        end
    endtask

    task automatic test_reset_medio;
        poner(0, 0, 1'b0);
        @(posedge clk); #1;
        esperado = modelo(0, 0, 1'b0);
        vectores++;
        if (observado !== esperado) begin
            fallos++;
            $display("FAIL medio_pre: got %b expected %b", observado, esperado);
        end
        poner(0, 0, 1'b1);
        @(posedge clk); #1;
        vectores++;
        if (observado !== 9'd0) begin
            fallos++;
            $display("FAIL medio_reset: got %b expected %b", observado, 9'd0);
        end
        poner(2, 1, 1'b0);
        @(posedge clk); #1;
        esperado = modelo(2, 1, 1'b0);
        vectores++;
        if (observado !== esperado) begin
            fallos++;
            $display("FAIL medio_post: got %b expected %b", observado, esperado);
        end
        previo = esperado;
    endtask

    task automatic test_barrido;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                poner(a, b, 1'b0);
                @(posedge clk); #1;
                esperado = modelo(a, b, 1'b0);
                vectores++;
                if (observado !== esperado) begin
                    fallos++;
                    $display("FAIL barrido a=%0d b=%0d: got %b expected %b",
                             a, b, observado, esperado);
                end
            end
        end
        previo = esperado;
    endtask

    task automatic test_aleatorio;
        int a;
        int b;
        bit r;
        for (int i = 0; i < 200; i++) begin
            a = int'($urandom_range(0, 15));
            b = int'($urandom_range(0, 15));
            r = ($urandom_range(0, 9) == 0);
            poner(a, b, r);
            #1;
            vectores++;
            if (observado !== previo) begin
                fallos++;
                $display("FAIL aleatorio_antes_%0d: got %b expected %b", i, observado, previo);
            end
            @(posedge clk); #1;
            esperado = modelo(a, b, r);
            vectores++;
            if (observado !== esperado) begin
                fallos++;
                $display("FAIL aleatorio_%0d a=%0d b=%0d rst=%0b: got %b expected %b",
                         i, a, b, r, observado, esperado);
            end
            previo = esperado;
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.carga_bateria1 = '0;
        bus.carga_bateria2 = '0;
        previo = 9'd0;
        test_reset();
        test_dirigido();
        test_reset_medio();
        test_barrido();
        test_aleatorio();
        $display("== %0d vectors applied, %0d miscompares ==", vectores, fallos);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
